// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and strobe encodings for the dmem port arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] WE_READ = 3'b000;
    localparam logic [2:0] WE_BYTE = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_WORD = 3'b100;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin, burst-bounded arbiter sharing the dmem data port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [2:0]            m0_we,
    output logic                  m0_gnt,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [2:0]            m1_we,
    output logic                  m1_gnt,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_we0,
    output logic                  mem_we1,
    output logic                  mem_we2
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    arb_state_t    state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] burst_cnt, cnt_inc, cnt_nxt;
    logic          xfer;
    logic [2:0]    we_sel;
    logic          rv0, rv1;

    assign m0_gnt = m0_req && (state == OWN0);
    assign m1_gnt = m1_req && (state == OWN1);
    assign xfer   = m0_gnt || m1_gnt;

    // Count including this cycle's transfer, so the MAX_BURST-th transfer hands over on the next edge
    assign cnt_inc = (xfer && (burst_cnt != CNT_MAX)) ? burst_cnt + 1'b1 : burst_cnt;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
                else if (m0_req)      state_nxt = OWN0;
                else if (m1_req)      state_nxt = OWN1;
            end
            OWN0: begin
                if (m0_req) begin
                    if (m1_req && (cnt_inc == CNT_MAX)) state_nxt = OWN1;
                end else begin
                    state_nxt = m1_req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (m1_req) begin
                    if (m0_req && (cnt_inc == CNT_MAX)) state_nxt = OWN0;
                end else begin
                    state_nxt = m0_req ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) begin
            if (state_nxt == OWN0) last_nxt = 1'b0;
            if (state_nxt == OWN1) last_nxt = 1'b1;
        end
        cnt_nxt = (state_nxt != state) ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Owner's payload is steered to the port even when it is not requesting; strobes only on a transfer
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        we_sel   = WE_READ;
        unique case (state)
            OWN0: begin
                mem_addr = m0_addr;
                mem_din  = m0_wdata;
                if (m0_gnt) we_sel = m0_we;
            end
            OWN1: begin
                mem_addr = m1_addr;
                mem_din  = m1_wdata;
                if (m1_gnt) we_sel = m1_we;
            end
            default: ;
        endcase
    end

    assign {mem_we2, mem_we1, mem_we0} = we_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= m0_gnt && (m0_we == WE_READ);
            rv1 <= m1_gnt && (m1_we == WE_READ);
        end
    end

    assign m0_rvalid = rv0;
    assign m1_rvalid = rv1;
    assign m0_rdata  = rv0 ? mem_dout : '0;
    assign m1_rdata  = rv1 ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural dmem
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [2:0]  m0_we, m1_we;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_we0, mem_we1, mem_we2;

    logic [31:0] memarr [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_we2(mem_we2)
    );

    // Synchronous-read dmem with byte/half/word write strobes, little-endian lanes
    always @(posedge clk) begin
        mem_dout <= memarr[mem_addr[9:2]];
        if (pl_en) memarr[pl_idx] <= pl_data;
        else if (mem_we2) memarr[mem_addr[9:2]] <= mem_din;
        else if (mem_we1) memarr[mem_addr[9:2]][mem_addr[1]*16 +: 16] <= mem_din[15:0];
        else if (mem_we0) memarr[mem_addr[9:2]][mem_addr[1:0]*8 +: 8] <= mem_din[7:0];
    end

    task automatic apply_reset();
        rst = 1'b1;
        m0_req = 0; m1_req = 0; m0_we = WE_READ; m1_we = WE_READ;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        m0_req = 1; m0_addr = 32'hC000; m0_we = WE_READ;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL reset_idle_gnt: got %b want 0", m0_gnt); end
        next_cycle(); next_cycle();
        #2;
        checks++; if ({m0_gnt, m0_rvalid} !== 2'b11) begin failures++; $display("FAIL reset_preburst: gnt,rvalid got %b want 11", {m0_gnt, m0_rvalid}); end
        rst = 1'b1;
        #1;
        checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin failures++; $display("FAIL reset_async_flags: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
        checks++; if ({mem_we2, mem_we1, mem_we0} !== 3'b000 || mem_addr !== 32'h0 || mem_din !== 32'h0) begin failures++; $display("FAIL reset_async_mem: we=%b addr=%h din=%h want 0", {mem_we2, mem_we1, mem_we0}, mem_addr, mem_din); end
        m0_req = 0;
        @(negedge clk); rst = 1'b0;
        next_cycle();
        checks++; if (dut.state !== IDLE || dut.last !== 1'b1 || m0_rvalid !== 1'b0) begin failures++; $display("FAIL reset_release: state=%0d last=%b rvalid=%b want IDLE,1,0", dut.state, dut.last, m0_rvalid); end
    endtask

    task automatic test_single_read();
        pl_en = 1; pl_idx = 8'd0; pl_data = 32'h12345678;
        apply_reset();
        pl_en = 0;
        m0_req = 1; m0_addr = 32'hC000; m0_we = WE_READ;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL single_cycle0_gnt: got %b want 0", m0_gnt); end
        next_cycle(); @(negedge clk);
        checks++; if (m0_gnt !== 1'b1 || mem_addr !== 32'hC000 || {mem_we2, mem_we1, mem_we0} !== 3'b000) begin failures++; $display("FAIL single_grant: gnt=%b addr=%h we=%b want 1,c000,000", m0_gnt, mem_addr, {mem_we2, mem_we1, mem_we0}); end
        next_cycle(); m0_req = 0; @(negedge clk);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin failures++; $display("FAIL single_rdata: rvalid=%b data=%h want 1,12345678", m0_rvalid, m0_rdata); end
        checks++; if (m1_gnt !== 1'b0 || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL single_m1_idle: gnt=%b rvalid=%b data=%h want 0", m1_gnt, m1_rvalid, m1_rdata); end
    endtask

    task automatic test_tie();
        apply_reset();
        m0_req = 1; m0_addr = 32'hC010; m0_we = WE_READ;
        m1_req = 1; m1_addr = 32'hC020; m1_we = WE_READ;
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin failures++; $display("FAIL tie_cycle0: got %b want 00", {m0_gnt, m1_gnt}); end
        next_cycle(); @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL tie_first: got %b want 10", {m0_gnt, m1_gnt}); end
        next_cycle(); m0_req = 0; @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt, m0_rvalid} !== 3'b001) begin failures++; $display("FAIL tie_drop: gnt0,gnt1,rv0 got %b want 001", {m0_gnt, m1_gnt, m0_rvalid}); end
        next_cycle(); @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 32'hC020) begin failures++; $display("FAIL tie_handover: gnt=%b addr=%h want 01,c020", {m0_gnt, m1_gnt}, mem_addr); end
    endtask

    task automatic test_burst_limit();
        bit exp0;
        apply_reset();
        m0_req = 1; m0_addr = 32'hC000; m0_we = WE_READ;
        m1_req = 1; m1_addr = 32'hC004; m1_we = WE_READ;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            next_cycle(); @(negedge clk);
            exp0 = ((k / MAXB) % 2) == 0;
            checks++;
            if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin
                failures++; $display("FAIL burst_k%0d: gnt0,gnt1 got %b%b want %b%b", k, m0_gnt, m1_gnt, exp0, !exp0);
            end
        end
    endtask

    task automatic test_lone_saturation();
        apply_reset();
        m1_req = 1; m1_addr = 32'hC008; m1_we = WE_READ;
        @(negedge clk);
        checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL lone_cycle0: got %b want 0", m1_gnt); end
        for (int k = 0; k < 20; k++) begin
            next_cycle(); @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== 2'b01) begin failures++; $display("FAIL lone_k%0d: gnt0,gnt1 got %b want 01", k, {m0_gnt, m1_gnt}); end
        end
        checks++; if (dut.burst_cnt !== 4'(MAXB)) begin failures++; $display("FAIL lone_burst_cnt: got %0d want %0d", dut.burst_cnt, MAXB); end
        m1_req = 0;
    endtask

    task automatic test_write_strobes();
        apply_reset();
        m1_req = 1; m1_addr = 32'hC004; m1_wdata = 32'hDEADBEEF; m1_we = WE_WORD;
        next_cycle(); @(negedge clk);
        checks++; if ({m1_gnt, mem_we2, mem_we1, mem_we0} !== 4'b1100 || mem_din !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_word: gnt,we=%b din=%h want 1100,deadbeef", {m1_gnt, mem_we2, mem_we1, mem_we0}, mem_din); end
        next_cycle(); m1_wdata = 32'h000000AA; m1_we = WE_BYTE; @(negedge clk);
        checks++; if ({m1_gnt, mem_we2, mem_we1, mem_we0} !== 4'b1001 || m1_rvalid !== 1'b0) begin failures++; $display("FAIL wr_byte: gnt,we=%b rvalid=%b want 1001,0", {m1_gnt, mem_we2, mem_we1, mem_we0}, m1_rvalid); end
        next_cycle(); m1_we = WE_READ; @(negedge clk);
        checks++; if ({m1_gnt, mem_we2, mem_we1, mem_we0} !== 4'b1000 || m1_rvalid !== 1'b0) begin failures++; $display("FAIL wr_readreq: gnt,we=%b rvalid=%b want 1000,0", {m1_gnt, mem_we2, mem_we1, mem_we0}, m1_rvalid); end
        next_cycle(); m1_req = 0; @(negedge clk);
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEAA) begin failures++; $display("FAIL wr_readback: rvalid=%b data=%h want 1,deadbeaa", m1_rvalid, m1_rdata); end
    endtask

    task automatic test_random();
        int owner, runlen, last_m, nxt, sel;
        bit rq[2], gp[2], eg[2], pend[2];
        logic [31:0] a[2], w[2], pdata[2], ea, ed;
        logic [2:0] we[2], ew;
        apply_reset();
        owner = -1; runlen = 0; last_m = 1;
        for (int i = 0; i < 2; i++) begin rq[i] = 0; gp[i] = 0; pend[i] = 0; pdata[i] = 0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(rq[i] && !gp[i])) begin
                    rq[i] = $urandom_range(0, 9) < 7;
                    a[i]  = 32'hC000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                    w[i]  = $urandom;
                    sel   = $urandom_range(0, 5);
                    we[i] = (sel < 3) ? WE_READ : (sel == 3) ? WE_BYTE : (sel == 4) ? WE_HALF : WE_WORD;
                end
            end
            m0_req = rq[0]; m0_addr = a[0]; m0_wdata = w[0]; m0_we = we[0];
            m1_req = rq[1]; m1_addr = a[1]; m1_wdata = w[1]; m1_we = we[1];
            @(negedge clk);
            eg[0] = (owner == 0) && rq[0];
            eg[1] = (owner == 1) && rq[1];
            ea = (owner < 0) ? 32'h0 : a[owner];
            ed = (owner < 0) ? 32'h0 : w[owner];
            ew = (eg[0] || eg[1]) ? we[owner] : WE_READ;
            checks++; if ({m0_gnt, m1_gnt} !== {eg[0], eg[1]}) begin failures++; $display("FAIL rnd_gnt c%0d: got %b%b want %b%b", cyc, m0_gnt, m1_gnt, eg[0], eg[1]); end
            checks++; if (mem_addr !== ea || mem_din !== ed || {mem_we2, mem_we1, mem_we0} !== ew) begin failures++; $display("FAIL rnd_mem c%0d: addr=%h din=%h we=%b want %h %h %b", cyc, mem_addr, mem_din, {mem_we2, mem_we1, mem_we0}, ea, ed, ew); end
            checks++; if (m0_rvalid !== pend[0] || m0_rdata !== (pend[0] ? pdata[0] : 32'h0)) begin failures++; $display("FAIL rnd_r0 c%0d: rvalid=%b data=%h want %b %h", cyc, m0_rvalid, m0_rdata, pend[0], pend[0] ? pdata[0] : 32'h0); end
            checks++; if (m1_rvalid !== pend[1] || m1_rdata !== (pend[1] ? pdata[1] : 32'h0)) begin failures++; $display("FAIL rnd_r1 c%0d: rvalid=%b data=%h want %b %h", cyc, m1_rvalid, m1_rdata, pend[1], pend[1] ? pdata[1] : 32'h0); end
            for (int i = 0; i < 2; i++) begin
                pend[i] = eg[i] && (we[i] == WE_READ);
                if (pend[i]) pdata[i] = memarr[a[i][9:2]];
            end
            if ((eg[0] || eg[1]) && runlen < MAXB) runlen++;
            if (owner < 0) nxt = (rq[0] && rq[1]) ? 1 - last_m : rq[0] ? 0 : rq[1] ? 1 : -1;
            else if (rq[owner]) nxt = (rq[1 - owner] && runlen == MAXB) ? 1 - owner : owner;
            else nxt = rq[1 - owner] ? 1 - owner : -1;
            if (nxt != owner) begin
                runlen = 0;
                if (nxt >= 0) last_m = nxt;
            end
            owner = nxt;
            gp[0] = eg[0]; gp[1] = eg[1];
            next_cycle();
        end
        m0_req = 0; m1_req = 0;
    endtask

    initial begin
        pl_en = 0; pl_idx = 0; pl_data = 0;
        test_reset();
        test_single_read();
        test_tie();
        test_burst_limit();
        test_lone_saturation();
        test_write_strobes();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
